// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: two per-source FIFOs (A = ALU, B = load unit) share one write port.
// Optional macro WB_RR_ARB_EN selects round-robin arbitration; otherwise B has fixed priority over A.

module regfile_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        not_empty,
  output logic [4:0]  head_addr,
  output logic [31:0] head_data,
  output logic [31:0] pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;
  logic [DEPTH-1:0] entry_valid;

  assign ready     = count_q < FULL;
  assign not_empty = count_q != '0;
  assign do_push   = push && ready;
  assign do_pop    = pop && not_empty;
  assign head_addr = mem_q[rd_ptr_q].addr;
  assign head_data = mem_q[rd_ptr_q].data;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = '{addr: push_addr, data: push_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the read pointer (mod DEPTH) is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset         = PW'(g) - rd_ptr_q;
    assign entry_valid[g] = {1'b0, offset} < count_q;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pend[mem_q[i].addr] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [31:0] pend,
  output logic        busy
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic        a_push, b_push, a_pop, b_pop;
  logic        a_ne, b_ne;
  logic [4:0]  a_head_addr, b_head_addr;
  logic [31:0] a_head_data, b_head_data;
  logic [31:0] a_pend, b_pend;

  logic        grant_valid;
  src_e        grant_src;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;

  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;

`ifdef WB_RR_ARB_EN
  src_e        last_q, last_d;
`endif

  assign a_push = a_valid && a_ready;
  assign b_push = b_valid && b_ready;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_addr (a_addr),
    .push_data (a_data),
    .pop       (a_pop),
    .ready     (a_ready),
    .not_empty (a_ne),
    .head_addr (a_head_addr),
    .head_data (a_head_data),
    .pend      (a_pend)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (b_pop),
    .ready     (b_ready),
    .not_empty (b_ne),
    .head_addr (b_head_addr),
    .head_data (b_head_data),
    .pend      (b_pend)
  );

  // last_q remembers the winner of the most recent contended grant; the other source goes next.
  always_comb begin
    grant_valid = a_ne || b_ne;
    grant_src   = SRC_A;
`ifdef WB_RR_ARB_EN
    last_d = last_q;
    if (a_ne && b_ne) begin
      grant_src = (last_q == SRC_A) ? SRC_B : SRC_A;
      last_d    = grant_src;
    end else if (b_ne) begin
      grant_src = SRC_B;
    end
`else
    if (b_ne) begin
      grant_src = SRC_B;
    end
`endif
  end

  assign a_pop = grant_valid && (grant_src == SRC_A);
  assign b_pop = grant_valid && (grant_src == SRC_B);

  assign grant_addr = (grant_src == SRC_B) ? b_head_addr : a_head_addr;
  assign grant_data = (grant_src == SRC_B) ? b_head_data : a_head_data;

  // Entries targeting x0 are still popped, but never reach the write port.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (grant_valid && (grant_addr != 5'd0)) begin
      we_d = 1'b1;
      wa_d = grant_addr;
      wd_d = grant_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

`ifdef WB_RR_ARB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SRC_A;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign pend = a_pend | b_pend;
  assign busy = a_ne || b_ne;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as stimulus is driven and
// compared whenever the write port fires. Honours WB_RR_ARB_EN for the arbitration-dependent steps.

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pend;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [36:0] sb [$];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .pend    (pend),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    sb.push_back({addr, data});
  endtask

  // Advance one edge, then sample; any write must match the head of the expected queue.
  task automatic tickCycle();
    logic [36:0] exp_e;
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_we", 32'(we), 32'd0);
      end else begin
        exp_e = sb.pop_front();
        checkOutput("wb_addr", 32'(wa), 32'(exp_e[36:32]));
        checkOutput("wb_data", wd, exp_e[31:0]);
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8; i++) begin
      tickCycle();
    end
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  wait_ticks;
    logic accepted;
    logic seen_ready;

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_we",      32'(we),      32'd0);
    checkOutput("rst_wa",      32'(wa),      32'd0);
    checkOutput("rst_wd",      wd,           32'd0);
    checkOutput("rst_pend",    pend,         32'd0);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] single write");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("single_a_ready", 32'(a_ready), 32'd1);
    expectWrite(5'd5, 32'hDEADBEEF);
    tickCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("single_we_early", 32'(we),   32'd0);
    checkOutput("single_pend5",    pend,      32'h0000_0020);
    checkOutput("single_busy",     32'(busy), 32'd1);
    tickCycle();
    checkOutput("single_we",       32'(we),   32'd1);
    checkOutput("single_pend_clr", pend,      32'd0);
    checkOutput("single_busy_clr", 32'(busy), 32'd0);
    tickCycle();
    checkOutput("single_we_drop",  32'(we),   32'd0);
    checkOutput("single_wa_hold",  32'(wa),   32'd5);
    checkOutput("single_wd_hold",  wd,        32'hDEADBEEF);

    $display("[TB] x0 discard");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    tickCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("x0_busy",     32'(busy),    32'd1);
    checkOutput("x0_pend",     pend,         32'd0);
    tickCycle();
    checkOutput("x0_no_we",    32'(we),      32'd0);
    checkOutput("x0_busy_clr", 32'(busy),    32'd0);
    checkOutput("x0_b_ready",  32'(b_ready), 32'd1);

    $display("[TB] contention");
    doReset();
`ifdef WB_RR_ARB_EN
    expectWrite(5'd3, 32'hB000_0003);
    expectWrite(5'd1, 32'hA000_0001);
    expectWrite(5'd4, 32'hB000_0004);
    expectWrite(5'd2, 32'hA000_0002);
`else
    expectWrite(5'd3, 32'hB000_0003);
    expectWrite(5'd4, 32'hB000_0004);
    expectWrite(5'd1, 32'hA000_0001);
    expectWrite(5'd2, 32'hA000_0002);
`endif
    applyStimulus(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd3, 32'hB000_0003);
    tickCycle();
    applyStimulus(1'b1, 5'd2, 32'hA000_0002, 1'b1, 5'd4, 32'hB000_0004);
    tickCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("cont_pend", pend, 32'h0000_0016);
    drain("cont");

    $display("[TB] full queue");
    doReset();
`ifdef WB_RR_ARB_EN
    expectWrite(5'd20, 32'h2020_2020);
    expectWrite(5'd10, 32'h1010_1010);
    expectWrite(5'd21, 32'h2121_2121);
    expectWrite(5'd11, 32'h1111_1111);
    expectWrite(5'd12, 32'h1212_1212);
`else
    expectWrite(5'd20, 32'h2020_2020);
    expectWrite(5'd21, 32'h2121_2121);
    expectWrite(5'd10, 32'h1010_1010);
    expectWrite(5'd11, 32'h1111_1111);
    expectWrite(5'd12, 32'h1212_1212);
`endif
    applyStimulus(1'b1, 5'd10, 32'h1010_1010, 1'b1, 5'd20, 32'h2020_2020);
    checkOutput("full_a_ready_start", 32'(a_ready), 32'd1);
    tickCycle();
    applyStimulus(1'b1, 5'd11, 32'h1111_1111, 1'b1, 5'd21, 32'h2121_2121);
    tickCycle();
    checkOutput("full_a_ready_low", 32'(a_ready), 32'd0);
    applyStimulus(1'b1, 5'd12, 32'h1212_1212, 1'b0, 5'd0, 32'd0);
    accepted   = 1'b0;
    wait_ticks = 0;
    for (int i = 0; i < 8; i++) begin
      if (!accepted) begin
        seen_ready = a_ready;
        tickCycle();
        wait_ticks++;
        if (seen_ready) begin
          accepted = 1'b1;
          applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
      end
    end
    checkOutput("full_third_accepted", 32'(accepted), 32'd1);
`ifdef WB_RR_ARB_EN
    checkOutput("full_wait_ticks", 32'(wait_ticks), 32'd2);
`else
    checkOutput("full_wait_ticks", 32'(wait_ticks), 32'd3);
`endif
    drain("full");

    $display("[TB] reset mid-operation");
    doReset();
    expectWrite(5'd7, 32'h7777_7777);
    applyStimulus(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd7, 32'h7777_7777);
    tickCycle();
    applyStimulus(1'b1, 5'd8, 32'h8888_8888, 1'b1, 5'd9, 32'h9999_9999);
    tickCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("mid_pend",    pend,         32'h0000_0340);
    checkOutput("mid_a_full",  32'(a_ready), 32'd0);
    checkOutput("mid_we",      32'(we),      32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_we",      32'(we),      32'd0);
    checkOutput("mid_rst_wa",      32'(wa),      32'd0);
    checkOutput("mid_rst_wd",      wd,           32'd0);
    checkOutput("mid_rst_pend",    pend,         32'd0);
    checkOutput("mid_rst_busy",    32'(busy),    32'd0);
    checkOutput("mid_rst_a_ready", 32'(a_ready), 32'd1);
    checkOutput("mid_rst_b_ready", 32'(b_ready), 32'd1);
    rst = 1'b0;
    sb.delete();
    tickCycle();
    checkOutput("post_rst_we", 32'(we), 32'd0);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per source queue (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset (asynchronous, active-high).
REQ-004 SHALL have ports a_valid (input, 1), a_ready (output, 1), a_addr (input, 5), a_data (input, 32), meaning source A (ALU) write request.
REQ-005 SHALL have ports b_valid (input, 1), b_ready (output, 1), b_addr (input, 5), b_data (input, 32), meaning source B (load/long-latency unit) write request.
REQ-006 SHALL have ports we (output, 1), wa (output, 5), wd (output, 32), meaning the register-file write port (enable, address, data).
REQ-007 SHALL have port pend, output, 32 bits, meaning per-register flag that a queued write is outstanding.
REQ-008 SHALL have port busy, output, 1 bit, meaning any queue non-empty.

Function
REQ-009 SHALL accept a request on a rising edge where valid and ready are both 1, pushing {addr, data} into that source's FIFO.
REQ-010 SHALL drive a_ready/b_ready from the registered occupancy count only (ready = count < DEPTH); no combinational path from any input to any ready.
REQ-011 SHALL, on a full queue, hold ready low; valid with ready low is ignored, and the source holds its request.
REQ-012 SHALL, each cycle, grant at most one non-empty queue, pop its head, and register it into we/wa/wd at the next edge.
REQ-013 SHALL give latency of exactly 2 edges from accepting edge to we=1 with an empty queue and no contention: accept at edge N, we/wa/wd valid from edge N+1 to N+2.
REQ-014 SHALL drive we=0 in any cycle following no grant; wa/wd hold their previous values.
REQ-015 SHALL pop entries with addr 0 normally but drive we=0 for them (x0 is never written).
REQ-016 SHALL allow push and pop of the same queue on the same edge; count is unchanged.
REQ-017 SHALL preserve per-source order; writes from one source reach the port in acceptance order.
REQ-018 SHALL set pend[r]=1 whenever any valid FIFO entry in either queue targets r (r != 0), derived from storage only; pend[0] is always 0.
REQ-019 SHALL assert busy whenever either count is non-zero.
REQ-020 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-021 SHALL, on rst=1 (asynchronous, active-high), immediately clear both counts and pointers, and set we=0, wa=0, wd=0, pend=0, busy=0, a_ready=1, b_ready=1, and the arbitration pointer to A.
REQ-022 SHALL discard all queued writes on reset mid-operation; no write issues in the first cycle after release.

Configuration
REQ-023 SHALL honour macro WB_RR_ARB_EN.
REQ-024 SHALL, without WB_RR_ARB_EN, use fixed priority: B is granted over A when both are non-empty.
REQ-025 SHALL, with WB_RR_ARB_EN, alternate grants when both are non-empty, using a 1-bit pointer that flips only after a contended grant; an uncontended grant leaves the pointer unchanged.

Verification
REQ-026 SHALL cover single write: a_valid with addr 5, data 0xDEADBEEF, both queues empty -> we=1, wa=5, wd=0xDEADBEEF exactly 2 edges after acceptance; pend[5]=1 for one cycle.
REQ-027 SHALL cover x0 discard: b request with addr 0, data 0x1234 -> entry consumed, we stays 0, b_ready returns to 1.
REQ-028 SHALL cover contention: A queue (addr 1, 2) and B queue (addr 3, 4) filled together -> fixed-priority build orders 3, 4, 1, 2; WB_RR_ARB_EN build orders 3, 1, 4, 2.
REQ-029 SHALL cover full queue: DEPTH=2, A pushes 3 back-to-back -> a_ready=0 after 2 accepts; the third request is accepted only after a pop, with no loss or reordering.
REQ-030 SHALL cover reset mid-operation: both queues full, rst pulsed asynchronously between edges -> outputs cleared immediately, no writes after release, readies=1.
